// File: rtl/alu_serial_pkg.sv
// Shared types for the serial ALU: operation codes, FSM states and the carry seed helper.
package alu_serial_pkg;

   typedef enum logic [2:0] {
      ADD   = 3'd0,
      SUB   = 3'd1,
      AND   = 3'd2,
      OR    = 3'd3,
      XOR   = 3'd4,
      RSHFT = 3'd5
   } AluOp;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } AluState;

   // Carry register value at accept: SUB is d1 + ~d2 + 1, so it starts with the +1.
   function automatic logic carry_seed(input logic [2:0] op, input logic cin);
      logic seed;
      case (op)
         ADD:     seed = cin;
         SUB:     seed = 1'b1;
         default: seed = 1'b0;
      endcase
      return seed;
   endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU datapath; carry in/out and carry into the top bit for overflow.
module alu_slice
   import alu_serial_pkg::*;
#(
   parameter int SLICE = 4
) (
   input  logic [2:0]       op,
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             shift_fill,
   input  logic             cin,
   output logic [SLICE-1:0] res,
   output logic             cout,
   output logic             cmsb
);

   logic [SLICE-1:0] b_eff_s;
   logic [SLICE:0]   sum_s;
   logic [SLICE:0]   shift_s;

   // Slice evaluation; carry into the MSB is recovered from the MSB sum bit
   always_comb begin
      if (op == SUB) begin
         b_eff_s = ~b;
      end else begin
         b_eff_s = b;
      end
      sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {{SLICE{1'b0}}, cin};
      shift_s = {shift_fill, b};
      res     = {SLICE{1'b0}};
      cout    = 1'b0;
      cmsb    = 1'b0;
      case (op)
         ADD, SUB: begin
            res  = sum_s[SLICE-1:0];
            cout = sum_s[SLICE];
            cmsb = sum_s[SLICE-1] ^ a[SLICE-1] ^ b_eff_s[SLICE-1];
         end
         AND:     res = a & b;
         OR:      res = a | b;
         XOR:     res = a ^ b;
         RSHFT:   res = shift_s[SLICE:1];
         default: res = {SLICE{1'b0}};
      endcase
   end

endmodule

// File: rtl/alu_serial.sv
// Serial ALU: one WIDTH-bit op per valid/ready handshake, evaluated SLICE bits per clock.
// Define ALU_SERIAL_FLAGS_EN to add the zero and ovf flag outputs.
module alu_serial
   import alu_serial_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             carry_in,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             carry_out
`ifdef ALU_SERIAL_FLAGS_EN
   ,
   output logic             zero,
   output logic             ovf
`endif
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if ((WIDTH % SLICE) != 0) begin : g_bad_slice
         $error("alu_serial: WIDTH (%0d) is not a multiple of SLICE (%0d)", WIDTH, SLICE);
      end
   endgenerate

   AluState          state_r;
   logic [CW-1:0]    count_r;
   logic [2:0]       op_r;
   logic             fill_r;
   logic [WIDTH-1:0] d1_r;
   logic [WIDTH-1:0] d2_r;
   logic [WIDTH-1:0] res_r;
   logic             carry_r;
   logic             carry_out_r;
   logic             out_valid_r;
   logic             in_ready_r;

   int               base_s;
   logic [SLICE-1:0] a_s;
   logic [SLICE-1:0] b_s;
   logic             fill_s;
   logic             last_s;
   logic [WIDTH-1:0] mask_s;
   logic [WIDTH-1:0] res_next_s;
   logic [SLICE-1:0] slice_res_s;
   logic             slice_cout_s;
   logic             slice_cmsb_s;
   logic             cout_final_s;

   // Active slice operands; the shift fill is the next d2 bit up, or carry_in above the MSB
   always_comb begin
      base_s     = int'(count_r) * SLICE;
      a_s        = SLICE'(d1_r >> base_s);
      b_s        = SLICE'(d2_r >> base_s);
      fill_s     = 1'(({fill_r, d2_r}) >> (base_s + SLICE));
      last_s     = (count_r == LAST);
      mask_s     = WIDTH'({SLICE{1'b1}}) << base_s;
      res_next_s = (res_r & ~mask_s) | (WIDTH'(slice_res_s) << base_s);
   end

   // Final carry_out: arithmetic carry, shifted-out bit, or 0
   always_comb begin
      case (op_r)
         ADD, SUB: cout_final_s = slice_cout_s;
         RSHFT:    cout_final_s = d2_r[0];
         default:  cout_final_s = 1'b0;
      endcase
   end

   alu_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .op         (op_r),
      .a          (a_s),
      .b          (b_s),
      .shift_fill (fill_s),
      .cin        (carry_r),
      .res        (slice_res_s),
      .cout       (slice_cout_s),
      .cmsb       (slice_cmsb_s)
   );

`ifdef ALU_SERIAL_FLAGS_EN
   logic nz_r;
   logic zero_r;
   logic ovf_r;
   logic ovf_final_s;
   logic zero_final_s;

   // Flags at the last slice; undefined op codes report no flags
   always_comb begin
      if ((op_r == ADD) || (op_r == SUB)) begin
         ovf_final_s = slice_cmsb_s ^ slice_cout_s;
      end else begin
         ovf_final_s = 1'b0;
      end
      if (op_r <= RSHFT) begin
         zero_final_s = ~(nz_r | (|slice_res_s));
      end else begin
         zero_final_s = 1'b0;
      end
   end

   // Sticky non-zero accumulation across slices and flag capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nz_r   <= 1'b0;
         zero_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         if ((state_r == IDLE) && in_valid) begin
            nz_r <= 1'b0;
         end else if (state_r == RUN) begin
            nz_r <= nz_r | (|slice_res_s);
            if (last_s) begin
               zero_r <= zero_final_s;
               ovf_r  <= ovf_final_s;
            end
         end
      end
   end

   assign zero = zero_r;
   assign ovf  = ovf_r;
`else
   logic unused_cmsb_s;
   assign unused_cmsb_s = slice_cmsb_s;
`endif

   // Handshake FSM, slice sequencing and the result/carry registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         count_r     <= {CW{1'b0}};
         op_r        <= 3'd0;
         fill_r      <= 1'b0;
         d1_r        <= {WIDTH{1'b0}};
         d2_r        <= {WIDTH{1'b0}};
         res_r       <= {WIDTH{1'b0}};
         carry_r     <= 1'b0;
         carry_out_r <= 1'b0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  op_r       <= op;
                  fill_r     <= carry_in;
                  d1_r       <= d1;
                  d2_r       <= d2;
                  count_r    <= {CW{1'b0}};
                  carry_r    <= carry_seed(op, carry_in);
                  in_ready_r <= 1'b0;
                  state_r    <= RUN;
               end
            end
            RUN: begin
               res_r   <= res_next_s;
               carry_r <= slice_cout_s;
               if (last_s) begin
                  count_r     <= {CW{1'b0}};
                  carry_out_r <= cout_final_s;
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end else begin
                  count_r <= count_r + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign res       = res_r;
   assign carry_out = carry_out_r;

endmodule
